// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - op/state encodings and default latencies for the multiply/divide sequencer
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 16;

  function automatic logic is_arith(input logic [3:0] op);
    return (op >= 4'(MD_MULT)) && (op <= 4'(MD_DIVU));
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational mult/multu/div/divu datapath producing {hi, lo}
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic        div0;
  logic        ovf;

  always_comb begin
    prod_s = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    prod_u = {32'd0, a} * {32'd0, b};
    div0   = (b == 32'd0);
    // substitute divisor keeps the dividers defined; div0 result is selected below
    b_safe = div0 ? 32'd1 : b;
    ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    q_s    = ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b_safe));
    r_s    = ovf ? 32'd0         : 32'($signed(a) % $signed(b_safe));
    q_u    = a / b_safe;
    r_u    = a % b_safe;

    hi = 32'd0;
    lo = 32'd0;
    case (op)
      4'(MD_MULT):  {hi, lo} = prod_s;
      4'(MD_MULTU): {hi, lo} = prod_u;
      4'(MD_DIV):   {hi, lo} = div0 ? {a, 32'hFFFF_FFFF} : {r_s, q_s};
      4'(MD_DIVU):  {hi, lo} = div0 ? {a, 32'hFFFF_FFFF} : {r_u, q_u};
      default:      {hi, lo} = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - mult/div launch FSM, latency counter, HI/LO registers and stall request
// Optional: MD_DIV0_HOLD_EN suppresses launch of div/divu with a zero divisor.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        start,
  output logic        busy_E,
  output logic        stall_md,
  output logic [31:0] hi_E,
  output logic [31:0] lo_E
);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      pend_hi, pend_lo;
  logic [31:0]      ar_hi, ar_lo;
  logic             is_div, launch_ok, commit, wr_hi, wr_lo;

  md_arith u_arith (
    .op (md_op_E),
    .a  (rs_E),
    .b  (rt_E),
    .hi (ar_hi),
    .lo (ar_lo)
  );

  assign is_div = (md_op_E == 4'(MD_DIV)) || (md_op_E == 4'(MD_DIVU));

`ifdef MD_DIV0_HOLD_EN
  assign launch_ok = is_arith(md_op_E) && !(is_div && (rt_E == 32'd0));
`else
  assign launch_ok = is_arith(md_op_E);
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      ST_IDLE: begin
        // gating with reset keeps start quiet while the async reset is held
        if (launch_ok && reset) begin
          start     = 1'b1;
          state_nxt = ST_RUN;
          cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else begin
          wr_hi = (md_op_E == 4'(MD_MTHI));
          wr_lo = (md_op_E == 4'(MD_MTLO));
        end
      end
      ST_RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi_E    <= 32'd0;
      lo_E    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        pend_hi <= ar_hi;
        pend_lo <= ar_lo;
      end
      if (commit) begin
        hi_E <= pend_hi;
        lo_E <= pend_lo;
      end
      if (wr_hi) hi_E <= rs_E;
      if (wr_lo) lo_E <= rs_E;
    end
  end

  assign busy_E   = (state == ST_RUN);
  assign stall_md = md_use_D & (start | busy_E);

  // the hazard unit must hold every HI/LO op in D while the unit is running
  a_no_op_in_run: assert property (@(posedge clk) disable iff (!reset)
    (state == ST_RUN) |-> !(is_arith(md_op_E) || md_op_E == 4'(MD_MTHI) || md_op_E == 4'(MD_MTLO)));

endmodule
